btb_assoc_predictor: RTL

Parametrised set-associative branch target buffer with per-entry saturating direction counters.
- Sits in the IF stage beside the PC register. The fetched PC is looked up each cycle, and the block returns a registered hit/taken/target prediction one cycle later.
- Resolved branches from EX write back through a dedicated update port that carries its own PC, so no PC shift register is needed.
- Generalises the single-way BTB to N ways, adds direction prediction, replacement, flush and reset.

---
 rtl/btb_assoc_predictor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/btb_assoc_predictor.sv
// Set-associative BTB with per-entry saturating direction counters.
// Lookup is registered; resolved branches update through their own port.
module btb_assoc_predictor #(
  parameter int DATA_WIDTH  = 32,
  parameter int SETS        = 16,
  parameter int WAYS        = 2,
  parameter int CTR_BITS    = 2,
  parameter int INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lookup_valid,
  input  logic [DATA_WIDTH-1:0] lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_hit,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [DATA_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [DATA_WIDTH-1:0] upd_target,
  input  logic                  flush
);

  localparam int OFF = $clog2(INSTR_BYTES);
  localparam int IDX = $clog2(SETS);
  localparam int TW  = DATA_WIDTH - OFF - IDX;
  localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  =
    CTR_BITS'(1) << (CTR_BITS - 1);

  logic [WAYS-1:0]       valid_q [SETS];
  logic [TW-1:0]         tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] tgt_q   [SETS][WAYS];
  logic [CTR_BITS-1:0]   ctr_q   [SETS][WAYS];

  logic [IDX-1:0] lk_idx;
  logic [TW-1:0]  lk_tag;
  logic [IDX-1:0] up_idx;
  logic [TW-1:0]  up_tag;

  assign lk_idx = lookup_pc[OFF+IDX-1:OFF];
  assign lk_tag = lookup_pc[DATA_WIDTH-1:OFF+IDX];
  assign up_idx = upd_pc[OFF+IDX-1:OFF];
  assign up_tag = upd_pc[DATA_WIDTH-1:OFF+IDX];

  if (OFF > 0) begin : g_unused
    logic unused_lo;
    assign unused_lo = ^upd_pc[OFF-1:0];
  end

  logic [WAYS-1:0] lk_match;
  logic [WAYS-1:0] up_match;
  logic [WAYS-1:0] up_inv;

  always_comb begin
    lk_match = '0;
    up_match = '0;
    for (int w = 0; w < WAYS; w++) begin
      lk_match[w] = valid_q[lk_idx][w] &&
                    (tag_q[lk_idx][w] == lk_tag);
      up_match[w] = valid_q[up_idx][w] &&
                    (tag_q[up_idx][w] == up_tag);
    end
    up_inv = ~valid_q[up_idx];
  end

  // Lowest-index priority for hits and free ways
  logic          lk_hit;
  logic [WW-1:0] lk_way;
  logic          up_hit;
  logic [WW-1:0] up_way;
  logic          has_inv;
  logic [WW-1:0] inv_way;

  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    up_hit  = 1'b0;
    up_way  = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_match[w]) begin
        lk_hit = 1'b1;
        lk_way = WW'(w);
      end
      if (up_match[w]) begin
        up_hit = 1'b1;
        up_way = WW'(w);
      end
      if (up_inv[w]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  logic                  lk_taken;
  logic [DATA_WIDTH-1:0] lk_target;

  assign lk_taken  = lk_hit &&
                     ctr_q[lk_idx][lk_way][CTR_BITS-1];
  assign lk_target = lk_taken ? tgt_q[lk_idx][lk_way] :
                     lookup_pc + DATA_WIDTH'(INSTR_BYTES);

  logic          upd_en;
  logic          alloc;
  logic          alloc_full;
  logic [WW-1:0] victim_ptr;
  logic [WW-1:0] victim;

  assign upd_en     = upd_valid && !flush;
  assign alloc      = upd_en && !up_hit && upd_taken;
  assign alloc_full = alloc && !has_inv;
  assign victim     = has_inv ? inv_way : victim_ptr;

  if (WAYS > 1) begin : g_ptr
    logic [WW-1:0] ptr_q [SETS];

    assign victim_ptr = ptr_q[up_idx];

    // Round-robin pointer only advances when a full set is replaced
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if (flush) begin
        for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if (alloc_full) begin
        ptr_q[up_idx] <= ptr_q[up_idx] + WW'(1);
      end
    end
  end else begin : g_noptr
    assign victim_ptr = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (alloc) begin
      valid_q[up_idx][victim] <= 1'b1;
    end
  end

  logic [CTR_BITS-1:0] cur_ctr;
  logic [CTR_BITS-1:0] nxt_ctr;

  always_comb begin
    cur_ctr = ctr_q[up_idx][up_way];
    nxt_ctr = cur_ctr;
    if (upd_taken) begin
      if (cur_ctr != CTR_MAX) nxt_ctr = cur_ctr + 1'b1;
    end else begin
      if (cur_ctr != '0) nxt_ctr = cur_ctr - 1'b1;
    end
  end

  // Payload needs no reset: valid gates every use
  always_ff @(posedge clk) begin
    if (upd_en && up_hit) begin
      ctr_q[up_idx][up_way] <= nxt_ctr;
      if (upd_taken) tgt_q[up_idx][up_way] <= upd_target;
    end else if (alloc) begin
      tag_q[up_idx][victim] <= up_tag;
      tgt_q[up_idx][victim] <= upd_target;
      ctr_q[up_idx][victim] <= CTR_WT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (flush) begin
      pred_valid  <= 1'b0;
    end else if (lookup_valid) begin
      pred_valid  <= 1'b1;
      pred_hit    <= lk_hit;
      pred_taken  <= lk_taken;
      pred_target <= lk_target;
    end else begin
      pred_valid  <= 1'b0;
    end
  end

  a_one_hit: assert property (
    @(posedge clk) disable iff (!rst_n)
    lookup_valid |-> $onehot0(lk_match)
  ) else $error("btb: multiple ways hit");

endmodule
